// File: rtl/rr_sel_mux.sv
// Channel selector with one output register: fixed-index or round-robin choice
// among requesting channels, with a one-hot grant telling the winner it was consumed.
module rr_sel_mux #(
    parameter int SIZE     = 8,
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CHANNELS*SIZE-1:0] IN,
    input  logic [CHANNELS-1:0]      REQ,
    input  logic [SW-1:0]            SEL,
    input  logic                     MODE,
    input  logic                     OUT_READY,
    output logic [CHANNELS-1:0]      GNT,
    output logic [SIZE-1:0]          OUT,
    output logic                     OUT_VALID,
    output logic [SW-1:0]            OUT_CH,
    output logic                     ERR
);

    // Handshake: a word moves downstream on any edge where OUT_VALID && OUT_READY;
    // the register may load a new word whenever it is empty or being drained (load).
    // Upstream channel k is consumed exactly on cycles where GNT[k]=1.
    logic          load;
    logic          sel_bad;
    logic          fx_hit;
    logic          rr_hit;
    logic [SW-1:0] rr_idx;
    logic [SW:0]   pos;
    logic          hit;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [SIZE-1:0] data_sel;

    assign load    = !OUT_VALID || OUT_READY;
    assign sel_bad = ({1'b0, SEL} >= (SW+1)'(CHANNELS));
    assign fx_hit  = !sel_bad && REQ[SEL];

    // Scan downward so the last match written is the nearest channel at or after ptr.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        pos    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (SW+1)'(i);
            if (pos >= (SW+1)'(CHANNELS))
                pos = pos - (SW+1)'(CHANNELS);
            if (REQ[pos[SW-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = pos[SW-1:0];
            end
        end
    end

    assign hit       = !RST && load && (MODE ? rr_hit : fx_hit);
    assign grant_idx = MODE ? rr_idx : SEL;
    assign ptr_next  = (grant_idx == SW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        GNT = '0;
        if (hit)
            GNT[grant_idx] = 1'b1;
    end

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (GNT[k])
                data_sel = IN[k*SIZE +: SIZE];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT       <= '0;
            OUT_CH    <= '0;
            OUT_VALID <= 1'b0;
            ERR       <= 1'b0;
            ptr       <= '0;
        end else begin
            ERR <= load && !MODE && sel_bad;
            if (load) begin
                OUT_VALID <= hit;
                if (hit) begin
                    OUT    <= data_sel;
                    OUT_CH <= grant_idx;
                    ptr    <= ptr_next;
                end
            end
        end
    end

endmodule
